// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared widths and the prefetch-queue entry type for the instruction-fetch
// stage of the 16-bit pipelined processor.
//   ADDR_W        : word-address width
//   INSTR_W       : instruction width
//   fetch_entry_t : one queued instruction together with its address
package fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// First-word-fall-through FIFO of fetch_entry_t used as the prefetch queue.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_entry at the tail this cycle
//   push_entry  : entry to write
//   pop         : drop the head entry this cycle
//   flush       : empty the queue (overrides push and pop)
//   head        : current head entry (valid whenever count != 0)
//   count       : number of entries held, 0..QDEPTH
// QDEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(QDEPTH+1)-1:0]  count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH+1);

    fetch_entry_t     storage [QDEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage, pointers and occupancy. A flush only rewinds the pointers;
    // stale storage contents are harmless because count gates validity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = storage[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: owns the PC, issues word addresses to a
// synchronous instruction memory (data returns one cycle after the request)
// and buffers returned instructions in a prefetch queue handed to decode
// over a valid/ready handshake. A one-cycle redirect flushes the queue and
// any in-flight fetch and restarts fetching at redirect_pc.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   imem_req        : fetch request this cycle
//   imem_addr       : word address of the request (registered PC)
//   imem_rdata      : instruction for the request issued last cycle
//   if_valid        : queue head valid toward decode
//   id_ready        : decode accepts the head this cycle
//   if_instr        : head instruction
//   if_pc           : head instruction address
//   if_pc_plus1     : if_pc + 1, modulo 2^16
//   redirect        : single-cycle flush-and-redirect
//   redirect_pc     : new fetch address, sampled with redirect
//   fetch_count     : pops so far            (only with FETCH_PERF_EN)
//   drop_count      : discarded fetches so far (only with FETCH_PERF_EN)
// Build option: define FETCH_PERF_EN to add the two performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                QDEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                if_valid,
    input  logic                id_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [ADDR_W-1:0]   if_pc_plus1,
    input  logic                redirect,
`ifdef FETCH_PERF_EN
    output logic [15:0]         fetch_count,
    output logic [15:0]         drop_count,
`endif
    input  logic [ADDR_W-1:0]   redirect_pc
);

    localparam int CNT_W = $clog2(QDEPTH+1);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              epoch;
    logic              inflight_epoch;

    logic [CNT_W-1:0]  q_count;
    fetch_entry_t      q_head;
    fetch_entry_t      q_push_entry;
    logic              pop;
    logic              accept;
    logic              push;
    logic [CNT_W:0]    occupancy;

    // Handshake and issue decisions. Occupancy counts the in-flight fetch as
    // already queued and a same-cycle pop as already freed, so an accepted
    // response always finds room while one instruction per cycle streams.
    always_comb begin
        if_valid  = (q_count != '0) && !redirect;
        pop       = if_valid && id_ready;
        occupancy = {1'b0, q_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        imem_req  = !redirect && (occupancy < (CNT_W+1)'(QDEPTH));
        accept    = inflight && (inflight_epoch == epoch);
        push      = accept && !redirect;
    end

    assign q_push_entry = '{instr: imem_rdata, pc: inflight_pc};

    // PC, in-flight tracking and epoch. Redirect wins over issue; the epoch
    // toggle marks any response from before the redirect as stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            inflight       <= 1'b0;
            epoch          <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= '0;
        end else begin
            inflight <= imem_req;
            if (redirect) begin
                pc    <= redirect_pc;
                epoch <= ~epoch;
            end else if (imem_req) begin
                pc             <= pc + ADDR_W'(1);
                inflight_epoch <= epoch;
                inflight_pc    <= pc;
            end
        end
    end

    fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (q_push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (q_head),
        .count      (q_count)
    );

    assign imem_addr   = pc;
    assign if_instr    = q_head.instr;
    assign if_pc       = q_head.pc;
    assign if_pc_plus1 = q_head.pc + ADDR_W'(1);

`ifdef FETCH_PERF_EN
    logic stale;

    // A response is dropped when it arrives in a redirect cycle or belongs
    // to an older epoch; a redirect also drops every entry still queued.
    assign stale = inflight && (redirect || !accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            drop_count  <= '0;
        end else begin
            if (pop) begin
                fetch_count <= fetch_count + 16'd1;
            end
            drop_count <= drop_count
                        + (redirect ? 16'(q_count) : 16'd0)
                        + 16'(stale);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Self-checking bench for fetch_stage. The instruction memory returns
// addr ^ 16'hA5A5 one cycle after each request (random data otherwise).
// Handed-off instructions are checked against a sequential-PC model:
// each pop must carry the next expected address, which restarts at
// redirect_pc on a redirect and at RESET_PC on reset.
module tb_fetch_stage;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] drop_count;
`endif

    int          checks = 0;
    int          fails = 0;
    logic [15:0] exp_pc = RST_PC;
    int          pops = 0;
    int          gap = 0;
    int          max_gap = 0;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .QDEPTH   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .id_ready    (id_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus1 (if_pc_plus1),
        .redirect    (redirect),
`ifdef FETCH_PERF_EN
        .fetch_count (fetch_count),
        .drop_count  (drop_count),
`endif
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory with no valid signal.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ 16'hA5A5) : 16'($urandom);
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then sample and score
    // any handshake that will complete at the next edge.
    task automatic applyStimulus(input logic rdy, input logic redir,
                                 input logic [15:0] rpc);
        @(posedge clk);
        #1;
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        if (redir) checkOutput("redirect_forces_invalid", {15'd0, if_valid}, 16'd0);
        if (if_valid && rdy) begin
            checkOutput("pop_pc", if_pc, exp_pc);
            checkOutput("pop_instr", if_instr, exp_pc ^ 16'hA5A5);
            checkOutput("pop_pc_plus1", if_pc_plus1, exp_pc + 16'd1);
            exp_pc = exp_pc + 16'd1;
            pops++;
        end
        if (redir) exp_pc = rpc;
        if (if_valid || redir) begin
            gap = 0;
        end else begin
            gap++;
            if (gap > max_gap) max_gap = gap;
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        id_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        #1;
        checkOutput("rst_if_valid", {15'd0, if_valid}, 16'd0);
        checkOutput("rst_if_instr", if_instr, 16'h0000);
        checkOutput("rst_if_pc", if_pc, 16'h0000);
        checkOutput("rst_if_pc_plus1", if_pc_plus1, 16'h0001);
        checkOutput("rst_imem_addr", imem_addr, RST_PC);
        checkOutput("rst_imem_req", {15'd0, imem_req}, 16'd1);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_pc = RST_PC;
        pops   = 0;
        gap    = 0;
    endtask

    initial begin
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;

        // Streaming from reset.
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("first_valid_cycle1", {15'd0, if_valid}, 16'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("first_valid_cycle2", {15'd0, if_valid}, 16'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000);
            checkOutput("stream_throughput", {15'd0, if_valid}, 16'd1);
        end

        // Back-pressure.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("bp_req_low", {15'd0, imem_req}, 16'd0);
        checkOutput("bp_valid_held", {15'd0, if_valid}, 16'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000);
            checkOutput("bp_resume_throughput", {15'd0, if_valid}, 16'd1);
        end

        // Redirect while streaming, coincident with a handshake.
        applyStimulus(1'b1, 1'b1, 16'h0200);
`ifdef FETCH_PERF_EN
        checkOutput("fetch_count_redirect", fetch_count, 16'(pops));
`endif
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("redir_r1_valid", {15'd0, if_valid}, 16'd0);
        checkOutput("redir_r1_req", {15'd0, imem_req}, 16'd1);
        checkOutput("redir_r1_addr", imem_addr, 16'h0200);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("redir_r2_valid", {15'd0, if_valid}, 16'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("redir_r3_valid", {15'd0, if_valid}, 16'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0000);

        // PC wrap.
        applyStimulus(1'b1, 1'b1, 16'hFFFE);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0000);

        // Randomized traffic with occasional redirects, some near the wrap.
        for (int i = 0; i < 300; i++) begin
            rdy   = ($urandom_range(0, 99) < 70);
            redir = ($urandom_range(0, 99) < 4);
            rpc   = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                : 16'($urandom);
            applyStimulus(rdy, redir, rpc);
        end
        checkOutput("random_progress", {15'd0, pops > 100}, 16'd1);
`ifdef FETCH_PERF_EN
        checkOutput("fetch_count_random", fetch_count, 16'(pops));
`endif

        // Reset mid-stream with a full queue and a fetch possibly in flight.
        applyStimulus(1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("rerst_valid_cycle1", {15'd0, if_valid}, 16'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("rerst_valid_cycle2", {15'd0, if_valid}, 16'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'h0000);

        checkOutput("max_invalid_gap", 16'(max_gap), 16'(max_gap <= 2 ? max_gap : 2));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
